hex_display_scan: RTL and testbench
===================================

Name: hex_display_scan

Overview:
- Parametrised, time-multiplexed multi-digit hex display driver for the board's common-anode 7-segment bank.
- Takes a NUM_DIGITS*4-bit value, typically the writeback result from the pipeline, and scans one nibble per refresh slot onto the shared segment lines.
- Adds tear-free frame-synchronous update, leading-zero blanking and a global blank, none of which the single-digit decoder has.

Parameters:
- NUM_DIGITS, 8, number of scanned digits; legal range 1..8. Derived localparam DATA_W = 4*NUM_DIGITS.
- REFRESH_DIV, 100000, clock cycles each digit is driven; legal range >= 2.
- CNT_W, 17, width of the refresh counter; must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- data_in  in  DATA_W  value to display; nibble k drives digit k, digit 0 is rightmost
- data_valid  in  1  single-cycle strobe that captures data_in into the shadow register
- lz_blank  in  1  1 = suppress leading zeros; digit 0 is never suppressed
- blank  in  1  1 = all anodes off
- seg  out  7  segment pattern {a,b,c,d,e,f,g}, a = MSB, active-high
- an  out  NUM_DIGITS  digit enables, active-low, one-hot-low
- frame_start  out  1  one-cycle pulse when the scan returns to digit 0
- update_pending  out  1  shadow holds data not yet shown

Behaviour:
- Reset (rst=0, async) clears all state:
  - refresh counter = 0, digit index = 0
  - shadow = 0, active = 0, update_pending = 0
  - seg = 7'b0000000, an = all ones, frame_start = 0
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - tick = (counter == REFRESH_DIV-1).
  - On tick, digit index advances modulo NUM_DIGITS.
- Frame boundary:
  - Occurs on the tick where the index wraps NUM_DIGITS-1 -> 0.
  - On that tick: active <= shadow if update_pending, update_pending <= 0, frame_start <= 1 the next cycle (one cycle wide).
  - If NUM_DIGITS = 1, every tick is a frame boundary.
- Capture:
  - data_valid=1 -> shadow <= data_in and update_pending <= 1 on the same edge.
  - If data_valid coincides with a frame-boundary tick: the old shadow transfers to active, the new data lands in shadow, and update_pending stays 1.
  - The last write before a boundary wins; intermediate writes are discarded.
- Decode uses nibble = active[4*idx +: 4] with this table:
  - 0 1111110, 1 0110000, 2 1101101, 3 1111001
  - 4 0110011, 5 1011011, 6 1011111, 7 1110000
  - 8 1111111, 9 1110011, A 1110111, b 0011111
  - C 1001110, d 0111101, E 1001111, F 1000111
- Leading-zero blanking:
  - When lz_blank=1, digit k>0 is suppressed (seg = 0000000, its an bit stays 1) if all nibbles k..NUM_DIGITS-1 of active are 0.
  - Value 0 therefore shows a single "0" on digit 0.
  - lz_blank is evaluated per cycle; no latching.
- blank=1 forces an = all ones on the next edge. seg keeps decoding. The scan continues and captures still work.
- Outputs are registered:
  - seg and an reflect the digit index one cycle after the index changes.
  - seg and an always switch on the same edge, so there is no ghosting skew between them.
- Anode pattern: an = ~(1 << idx), gated by blank and leading-zero suppression.
- Deassertion of rst is assumed synchronised externally.
- Reset mid-scan returns immediately to digit 0 with the display dark. The first lit output appears one cycle after reset release, showing "0" on digit 0.

Test Plan:
- Bench: NUM_DIGITS=4, REFRESH_DIV=4.
- Reset: hold rst=0 mid-scan, then release -> while rst=0, seg=0000000 and an=1111. One cycle after release, an=1110 and seg=1111110. frame_start fires at cycle 16.
- Update at frame boundary: pulse data_valid with 16'h12AF at cycle 5 -> update_pending=1 until the boundary tick at cycle 15. Digits then show F,A,2,1 with an sequence 1110, 1101, 1011, 0111, each held 4 cycles.
- Collision: data_valid with 16'h0003 on the boundary tick, while the shadow holds 16'h00FF -> the next frame shows 00FF and update_pending remains 1. The frame after that shows 0003.
- Leading-zero blanking: active=16'h0030, lz_blank=1 -> an=1110 (seg 1111110) and an=1101 (seg 1111001) are driven. Digits 2-3 keep an=1111 during their slots. With active=0, only digit 0 lights.
- Blank: set blank=1 for 20 cycles -> an=1111 throughout. The index keeps advancing, and frame_start still pulses every 16 cycles.
- Back-to-back writes: data_valid with 16'h1111 then 16'h2222 on consecutive cycles within one frame -> only 2222 is ever displayed.

Source files
------------

// File: rtl/hex_display_scan.sv
// Time-multiplexed hex display driver for a common-anode 7-segment bank.
// A shadow register takes new values at any time; they become visible only at a frame boundary.
module hex_display_scan #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17,
  localparam int DATA_W     = 4 * NUM_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  data_valid,
  input  logic                  lz_blank,
  input  logic                  blank,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_start,
  output logic                  update_pending
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [DATA_W-1:0]     shadow;
  logic [DATA_W-1:0]     active;
  logic                  tick;
  logic                  wrap;
  logic [3:0]            nibble;
  logic [6:0]            seg_next;
  logic [NUM_DIGITS-1:0] an_next;
  logic [NUM_DIGITS-1:0] zero_from;
  logic                  suppress;
  logic                  run_zero;

  assign tick = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign wrap = tick && (idx == IDX_W'(NUM_DIGITS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= wrap ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // data_valid is a one-cycle strobe with no back-pressure: the most recent
  // capture before a boundary wins. A capture on the boundary tick still
  // lets the previous shadow through and keeps the new value pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow         <= '0;
      active         <= '0;
      update_pending <= 1'b0;
      frame_start    <= 1'b0;
    end else begin
      frame_start <= wrap;
      if (wrap && update_pending) begin
        active <= shadow;
      end
      if (data_valid) begin
        shadow         <= data_in;
        update_pending <= 1'b1;
      end else if (wrap) begin
        update_pending <= 1'b0;
      end
    end
  end

  // zero_from[k] is set when nibbles k..top of the displayed value are all zero.
  always_comb begin
    zero_from = '0;
    run_zero  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      run_zero     = run_zero & (active[4*k +: 4] == 4'h0);
      zero_from[k] = run_zero;
    end
  end

  assign nibble   = active[4*idx +: 4];
  assign suppress = lz_blank && (idx != '0) && zero_from[idx];

  always_comb begin
    seg_next = 7'b0000000;
    case (nibble)
      4'h0: seg_next = 7'b1111110;
      4'h1: seg_next = 7'b0110000;
      4'h2: seg_next = 7'b1101101;
      4'h3: seg_next = 7'b1111001;
      4'h4: seg_next = 7'b0110011;
      4'h5: seg_next = 7'b1011011;
      4'h6: seg_next = 7'b1011111;
      4'h7: seg_next = 7'b1110000;
      4'h8: seg_next = 7'b1111111;
      4'h9: seg_next = 7'b1110011;
      4'hA: seg_next = 7'b1110111;
      4'hB: seg_next = 7'b0011111;
      4'hC: seg_next = 7'b1001110;
      4'hD: seg_next = 7'b0111101;
      4'hE: seg_next = 7'b1001111;
      4'hF: seg_next = 7'b1000111;
      default: seg_next = 7'b0000000;
    endcase
    if (suppress) begin
      seg_next = 7'b0000000;
    end
  end

  always_comb begin
    an_next = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      an_next[k] = !((idx == IDX_W'(k)) && !blank && !suppress);
    end
  end

  // seg and an share one register stage so they always change together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg <= 7'b0000000;
      an  <= '1;
    end else begin
      seg <= seg_next;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_hex_display_scan.sv
// Directed bench for hex_display_scan with 4 digits and a 4-cycle refresh slot.
// Checks happen 1 time unit after each rising edge; cyc counts edges since reset release.
module tb_hex_display_scan;

  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S1 = 7'b0110000;
  localparam logic [6:0] S2 = 7'b1101101;
  localparam logic [6:0] S3 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0110011;
  localparam logic [6:0] SA = 7'b1110111;
  localparam logic [6:0] SF = 7'b1000111;
  localparam logic [6:0] SOFF = 7'b0000000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] data_in = '0;
  logic        data_valid = 1'b0;
  logic        lz_blank = 1'b0;
  logic        blank = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_start;
  logic        update_pending;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [10:0] exp_q[$];

  hex_display_scan #(.NUM_DIGITS(4), .REFRESH_DIV(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .lz_blank(lz_blank), .blank(blank), .seg(seg), .an(an),
    .frame_start(frame_start), .update_pending(update_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  // Strobe data_valid so the capture happens on edge number at_edge.
  task automatic write(input logic [15:0] v, input int at_edge);
    run_to(at_edge - 1);
    data_in    = v;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    run_to(6);
    rst = 1'b0;
    #1;
    check("rst_seg", seg, SOFF);
    check("rst_an", an, 4'b1111);
    check("rst_pend", update_pending, 1'b0);
    check("rst_fs", frame_start, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_an", an, 4'b1111);
    check("rst_hold_seg", seg, SOFF);
    rst = 1'b1;
    cyc = 0;

    run_to(1);
    check("first_an", an, 4'b1110);
    check("first_seg", seg, S0);
    check("first_fs", frame_start, 1'b0);
    write(16'h12AF, 5);
    check("pend_set", update_pending, 1'b1);
    run_to(6);
    check("d1_an", an, 4'b1101);
    check("d1_seg", seg, S0);
    run_to(15);
    check("pend_15", update_pending, 1'b1);
    check("fs_15", frame_start, 1'b0);
    run_to(16);
    check("fs_16", frame_start, 1'b1);
    check("pend_16", update_pending, 1'b0);
    run_to(17);
    check("fs_17", frame_start, 1'b0);

    for (int i = 0; i < 4; i++) exp_q.push_back({4'b1110, SF});
    for (int i = 0; i < 4; i++) exp_q.push_back({4'b1101, SA});
    for (int i = 0; i < 4; i++) exp_q.push_back({4'b1011, S2});
    for (int i = 0; i < 4; i++) exp_q.push_back({4'b0111, S1});
    for (int i = 0; i < 16; i++) begin
      if (i > 0) step();
      check("frame_12af", {an, seg}, exp_q.pop_front());
    end
    check("fs_32", frame_start, 1'b1);

    write(16'h00FF, 40);
    write(16'h0003, 48);
    check("coll_pend", update_pending, 1'b1);
    check("coll_fs", frame_start, 1'b1);
    run_to(49);
    check("coll_d0", {an, seg}, {4'b1110, SF});
    run_to(53);
    check("coll_d1", {an, seg}, {4'b1101, SF});
    run_to(57);
    check("coll_d2", {an, seg}, {4'b1011, S0});
    run_to(64);
    check("coll_pend64", update_pending, 1'b0);
    run_to(65);
    check("next_d0", {an, seg}, {4'b1110, S3});
    run_to(69);
    check("next_d1", {an, seg}, {4'b1101, S0});

    write(16'h0030, 72);
    run_to(80);
    lz_blank = 1'b1;
    run_to(81);
    check("lz_d0", {an, seg}, {4'b1110, S0});
    run_to(85);
    check("lz_d1", {an, seg}, {4'b1101, S3});
    run_to(89);
    check("lz_d2", {an, seg}, {4'b1111, SOFF});
    write(16'h0000, 90);
    run_to(93);
    check("lz_d3", {an, seg}, {4'b1111, SOFF});
    run_to(97);
    check("lz0_d0", {an, seg}, {4'b1110, S0});
    run_to(101);
    check("lz0_d1", {an, seg}, {4'b1111, SOFF});
    run_to(103);
    lz_blank = 1'b0;
    run_to(105);
    check("nolz_d2", {an, seg}, {4'b1011, S0});

    run_to(112);
    check("fs_112", frame_start, 1'b1);
    blank = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("blank_an", an, 4'b1111);
      if (cyc == 113) check("blank_seg", seg, S0);
      if (cyc == 119) begin
        data_in    = 16'h0042;
        data_valid = 1'b1;
      end
      if (cyc == 120) begin
        data_valid = 1'b0;
        check("blank_pend", update_pending, 1'b1);
      end
      if (cyc == 128) begin
        check("blank_fs", frame_start, 1'b1);
        check("blank_pend128", update_pending, 1'b0);
      end
    end
    blank = 1'b0;
    run_to(133);
    check("unblank_d1", {an, seg}, {4'b1101, S4});

    write(16'h1111, 136);
    write(16'h2222, 137);
    check("b2b_pend", update_pending, 1'b1);
    run_to(144);
    check("fs_144", frame_start, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step();
      check("b2b_seg", seg, S2);
      check("b2b_an", an, 4'b1111 & ~(4'b0001 << (i / 4)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
